// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 64-bit data memory.
// Optional DMEM_ARB_ERR_EN: misaligned or out-of-range accesses complete with err, skipping memory.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned RR_INIT   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [63:0] a_addr,
  input  logic [63:0] a_wdata,
  output logic        a_ack,
  output logic [63:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [63:0] b_addr,
  input  logic [63:0] b_wdata,
  output logic        b_ack,
  output logic [63:0] b_rdata,
  output logic        b_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [63:0] LastAddr = 64'(MEM_BYTES - 8);

  state_e      state_q, state_d;
  logic        pri_q, pri_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] a_rdata_q, b_rdata_q;

  logic        win;
  logic [63:0] win_addr;
  logic        range_bad;
  logic        win_bad;

  // pri names the port that wins a tie: 0 = A, 1 = B.
  assign win       = (a_req && b_req) ? pri_q : b_req;
  assign win_addr  = win ? b_addr : a_addr;
  assign range_bad = (win_addr[2:0] != 3'd0) || (win_addr > LastAddr);

`ifdef DMEM_ARB_ERR_EN
  assign win_bad = range_bad;
`else
  logic unused_range_bad;
  assign unused_range_bad = range_bad;
  assign win_bad          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          gnt_d   = win;
          pri_d   = ~win;
          we_d    = win ? b_we : a_we;
          addr_d  = win_addr;
          wdata_d = win ? b_wdata : a_wdata;
          err_d   = win_bad;
          state_d = win_bad ? StResp : StIssue;
        end
      end
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pri_q   <= (RR_INIT != 0);
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read data is captured on the edge that ends ISSUE, only for the granted port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else if (state_q == StIssue && !we_q) begin
      if (gnt_q) begin
        b_rdata_q <= mem_rdata;
      end else begin
        a_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_read  = (state_q == StIssue) && !we_q;
  assign mem_write = (state_q == StIssue) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign a_ack     = (state_q == StResp) && !gnt_q;
  assign b_ack     = (state_q == StResp) && gnt_q;
  assign a_err     = a_ack && err_q;
  assign b_err     = b_ack && err_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus random traffic against a
// transaction-level model (byte memory image, tie-break pointer, expected read data).
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam int MemBytes = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [63:0] a_rdata, b_rdata;
  logic        mem_read, mem_write, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  logic        req_v [2];
  logic        we_v  [2];
  logic [63:0] addr_v[2];
  logic [63:0] wd_v  [2];

  assign a_req   = req_v[0];
  assign a_we    = we_v[0];
  assign a_addr  = addr_v[0];
  assign a_wdata = wd_v[0];
  assign b_req   = req_v[1];
  assign b_we    = we_v[1];
  assign b_addr  = addr_v[1];
  assign b_wdata = wd_v[1];

  dmem_arbiter #(.MEM_BYTES(MemBytes), .RR_INIT(0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .b_err     (b_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Attached memory: combinational little-endian read, posedge write.
  logic [7:0] init_img [MemBytes];
  logic [7:0] mem      [MemBytes];
  logic       mem_loaded = 1'b0;

  always_comb begin
    logic [5:0] idx;
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      idx = mem_addr[5:0] + 6'(i);
      mem_rdata[8*i +: 8] = mem[idx];
    end
  end

  always @(posedge clk) begin
    logic [5:0] idx;
    if (!mem_loaded) begin
      for (int i = 0; i < MemBytes; i++) mem[i] <= init_img[i];
      mem_loaded <= 1'b1;
    end else if (mem_write) begin
      for (int i = 0; i < 8; i++) begin
        idx = mem_addr[5:0] + 6'(i);
        mem[idx] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [MemBytes];
  logic [63:0] exp_rd  [2];
  bit          exp_pri;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [63:0] read_ref(input logic [63:0] addr);
    logic [63:0] r;
    logic [5:0]  idx;
    for (int i = 0; i < 8; i++) begin
      idx = addr[5:0] + 6'(i);
      r[8*i +: 8] = ref_mem[idx];
    end
    return r;
  endfunction

  task automatic write_ref(input logic [63:0] addr, input logic [63:0] data);
    logic [5:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx = addr[5:0] + 6'(i);
      ref_mem[idx] = data[8*i +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Port p requests cnt[p] times with req held between accesses; every cycle is checked.
  task automatic run(input int na, input int nb, input bit wa, input bit wb,
                     input logic [63:0] aa, input logic [63:0] ab,
                     input logic [63:0] da, input logic [63:0] db);
    int          cnt[2];
    bit          w[2];
    logic [63:0] ad[2];
    logic [63:0] dt[2];
    bit          g, bad;
    cnt[0] = na; cnt[1] = nb;
    w[0] = wa;   w[1] = wb;
    ad[0] = aa;  ad[1] = ab;
    dt[0] = da;  dt[1] = db;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = (cnt[p] > 0); we_v[p] = w[p]; addr_v[p] = ad[p]; wd_v[p] = dt[p];
    end
    chk("pre_grant_idle", 64'({mem_read, mem_write, busy}), 64'd0);
    while (cnt[0] > 0 || cnt[1] > 0) begin
      g = (cnt[0] > 0 && cnt[1] > 0) ? exp_pri : (cnt[1] > 0);
      exp_pri = !g;
      bad = ErrEn && ((ad[g][2:0] != 3'd0) || (ad[g] > 64'(MemBytes - 8)));
      if (!bad) begin
        @(negedge clk);
        chk("issue_ctl", 64'({mem_read, mem_write, busy, a_ack, b_ack}),
            64'({!w[g], w[g], 1'b1, 2'b00}));
        chk("issue_addr", mem_addr, ad[g]);
        chk("issue_wdata", mem_wdata, dt[g]);
        if (w[g]) write_ref(ad[g], dt[g]);
        else exp_rd[g] = read_ref(ad[g]);
        // Granted payload is latched, so scrambling it now must not matter.
        addr_v[g] = {$urandom, $urandom};
        wd_v[g]   = {$urandom, $urandom};
        we_v[g]   = !w[g];
      end
      @(negedge clk);
      chk("resp_ack", 64'({a_ack, b_ack, a_err, b_err, busy, mem_read, mem_write}),
          64'({g == 1'b0, g == 1'b1, bad && g == 1'b0, bad && g == 1'b1, 1'b1, 2'b00}));
      chk("a_rdata", a_rdata, exp_rd[0]);
      chk("b_rdata", b_rdata, exp_rd[1]);
      cnt[g]--;
      req_v[g] = (cnt[g] > 0); we_v[g] = w[g]; addr_v[g] = ad[g]; wd_v[g] = dt[g];
      @(negedge clk);
      chk("idle_gap", 64'({busy, a_ack, b_ack, mem_read, mem_write}), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < MemBytes; i++) init_img[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      init_img[i]      = 8'h00;
      init_img[16 + i] = 8'h00;
    end
    init_img[0]  = 8'h0F;
    init_img[16] = 8'h01;
    for (int i = 0; i < MemBytes; i++) ref_mem[i] = init_img[i];
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_pri   = 1'b0;

    // Reset held with random inputs: everything quiet.
    reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++) begin
        req_v[p] = 1'($urandom); we_v[p] = 1'($urandom);
        addr_v[p] = {$urandom, $urandom}; wd_v[p] = {$urandom, $urandom};
      end
      @(negedge clk);
      chk("rst_ctl", 64'({a_ack, a_err, b_ack, b_err, mem_read, mem_write, busy}), 64'd0);
      chk("rst_a_rdata", a_rdata, 64'd0);
      chk("rst_b_rdata", b_rdata, 64'd0);
    end
    chk("rst_mem_addr", mem_addr, 64'd0);
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wd_v[p] = '0;
    end
    reset_n = 1'b1;
    @(negedge clk);

    // A write then read back at address 8.
    run(1, 0, 1'b1, 1'b0, 64'd8, 64'd0, 64'h1122334455667788, 64'd0);
    run(1, 0, 1'b0, 1'b0, 64'd8, 64'd0, 64'd0, 64'd0);
    chk("a_read8", a_rdata, 64'h1122334455667788);

    // B read of preloaded address 0; A's data stays put.
    run(0, 1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    chk("b_read0", b_rdata, 64'h000000000000000F);
    chk("a_kept", a_rdata, 64'h1122334455667788);

    // Both held for two accesses each: A,B,A,B, three cycles apart.
    run(2, 2, 1'b0, 1'b0, 64'd24, 64'd32, 64'd0, 64'd0);

    // Misaligned and top-of-range addresses.
    run(1, 0, 1'b0, 1'b0, 64'd3, 64'd0, 64'd0, 64'd0);
    if (ErrEn) run(1, 0, 1'b0, 1'b0, 64'd60, 64'd0, 64'd0, 64'd0);

    // Reset asserted in the middle of ISSUE of a write to address 16.
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 64'd16; wd_v[0] = 64'hFF;
    @(negedge clk);
    chk("abort_issue", 64'(mem_write), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("abort_async", 64'({mem_write, busy}), 64'd0);
    req_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_no_ack", 64'({a_ack, b_ack}), 64'd0);
    chk("abort_mem16", 64'(mem[16]), 64'd1);
    chk("abort_rdata", a_rdata, 64'd0);
    reset_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_pri   = 1'b0;
    @(negedge clk);
    chk("abort_no_ack2", 64'({a_ack, busy}), 64'd0);
    run(1, 0, 1'b0, 1'b0, 64'd16, 64'd0, 64'd0, 64'd0);
    chk("abort_read16", a_rdata, 64'h0000000000000001);

    // Random traffic, aligned in-range addresses.
    for (int k = 0; k < 30; k++) begin
      int na, nb;
      na = $urandom_range(0, 2);
      nb = $urandom_range(0, 2);
      if (na == 0 && nb == 0) na = 1;
      run(na, nb, 1'($urandom), 1'($urandom),
          64'(8 * $urandom_range(0, 7)), 64'(8 * $urandom_range(0, 7)),
          {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and access sequencer in front of the 64-bit, byte-addressed, little-endian data memory. The memory has a combinational read and a posedge write. Port A is the CPU load/store unit; port B is the DMA/test-loader path. The block grants one requester at a time with round-robin on ties, drives the memory control/address/data for exactly one cycle per access, and returns a one-cycle ack with captured read data.

Parameters:
MEM_BYTES, 64, size of the attached memory in bytes; used for the range check.
RR_INIT, 0, tie-break port after reset (0 = A, 1 = B).

Ports:
clk  input  1  system clock, all state on posedge
reset_n  input  1  asynchronous, active-low reset
a_req  input  1  port A request, held high until a_ack
a_we  input  1  port A write (1) / read (0)
a_addr  input  64  port A byte address
a_wdata  input  64  port A write data
a_ack  output  1  port A one-cycle completion pulse
a_rdata  output  64  port A read data, valid from a_ack, held until the next A read completes
a_err  output  1  port A error, qualified by a_ack
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err  same directions, widths and meanings as port A, for port B
mem_read  output  1  to memory MemRead
mem_write  output  1  to memory MemWrite
mem_addr  output  64  to memory Mem_Addr
mem_wdata  output  64  to memory Write_Data
mem_rdata  input  64  from memory Read_Data
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE, pri = RR_INIT, gnt_id 0, latched addr/wdata/we 0, a_rdata/b_rdata 0, all ack/err/mem_read/mem_write/busy 0.
- FSM states:
  - IDLE: no request → stay in IDLE. Any request → latch gnt_id, we, addr and wdata from the winner, then go to ISSUE.
  - ISSUE: lasts exactly 1 cycle, then RESP.
  - RESP: lasts exactly 1 cycle, then IDLE.
- Arbitration in IDLE:
  - Single request wins.
  - Both requesting → port selected by pri wins.
  - After every grant, pri := the non-granted port.
- ISSUE outputs: mem_addr = latched addr, mem_wdata = latched wdata, mem_write = we, mem_read = !we.
  - The memory write occurs at the posedge ending ISSUE.
  - For reads, mem_rdata is captured into the granted port's rdata register at that same edge.
- mem_read and mem_write are decoded from state and are 0 in IDLE and RESP. mem_addr and mem_wdata always reflect the latched registers.
- RESP: ack = 1 for the granted port only; err per the optional feature, otherwise 0.
- Latency: request seen in IDLE at cycle N → ISSUE at N+1 → ack at N+2. Next grant evaluated at N+3. Maximum throughput is 1 access per 3 cycles.
- Requests are latched at grant. Changes to addr, wdata or we after the grant cycle are ignored. Dropping req before ack does not cancel the access; ack still pulses.
- A requester must deassert req, or present a new request, in the cycle after ack. req still high in IDLE is treated as a new request.
- The non-granted port's rdata is untouched. Writes do not modify rdata.
- Reset mid-operation: state returns to IDLE asynchronously and mem_write drops immediately. A write whose ISSUE edge coincides with or follows reset assertion is not performed. No ack is produced for the aborted access.
- Width rules: addresses pass through unmodified at 64 bits. No byte-lane masking; every access is 8 bytes.

Optional Feature:
DMEM_ARB_ERR_EN
- Defined: at grant in IDLE, if addr[2:0] != 0 or addr > MEM_BYTES-8, the FSM goes directly to RESP, skipping ISSUE.
  - No mem_read/mem_write assertion; rdata unchanged.
  - ack and err both high in RESP; latency 1 cycle (ack at N+1).
  - pri still rotates.
- Undefined: no check, err outputs tied 0, and every access goes through ISSUE.

Test Plan:
- Hold reset_n=0 with random inputs → all outputs 0 and busy 0. Release, then set a_req → mem_write/mem_read stay 0 until ISSUE.
- A write addr 8, data 0x1122334455667788 at cycle N → mem_write=1 only at N+1, mem_addr=8, a_ack=1 at N+2. Then A read addr 8 → a_rdata=0x1122334455667788 at ack.
- With RR_INIT=0, a_req and b_req both held continuously for 4 accesses → grant order A,B,A,B, acks 3 cycles apart, busy low for one cycle between accesses.
- Memory model preloaded with byte0=15; B read addr 0 → b_rdata=0x000000000000000F at b_ack, a_rdata unchanged.
- Assert reset_n=0 mid-ISSUE of an A write to addr 16 with data 0xFF → mem_write drops asynchronously, memory byte 16 stays 1, a_ack never pulses.
- Address 3 and address 60:
  - With DMEM_ARB_ERR_EN: A read addr 3 → a_ack=1 and a_err=1 at N+1, mem_read never asserted. Addr 60 gives the same result.
  - Without DMEM_ARB_ERR_EN: A read addr 3 is issued normally with a_err=0.
